// File: rtl/ysyx_23060221_pkg.sv
// Shared definitions for the write-back unit: write-back source codes, FSM state
// encoding and the write-value selector.
package ysyx_23060221_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_CSR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WRITE  = 2'b01,
        ST_NOTIFY = 2'b10
    } wbu_state_t;

    // pc + 4 wraps naturally in 32 bits.
    function automatic logic [31:0] wb_select(
        input logic [1:0]  sel,
        input logic [31:0] res,
        input logic [31:0] ldata,
        input logic [31:0] pc,
        input logic [31:0] csrdata
    );
        logic [31:0] value;
        case (sel)
            WB_ALU:  value = res;
            WB_LOAD: value = ldata;
            WB_PC4:  value = pc + 32'd4;
            WB_CSR:  value = csrdata;
            default: value = res;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/ysyx_23060221_regfile.sv
// Integer register file: one synchronous write port, two combinational read
// ports, x0 hardwired to zero, asynchronous active-low clear of all entries.
module ysyx_23060221_regfile #(
    parameter int NR_REG = 16,
    localparam int RW = $clog2(NR_REG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [RW-1:0] raddr1,
    input  logic [RW-1:0] raddr2,
    output logic [31:0]   rdata1,
    output logic [31:0]   rdata2
);

    logic [31:0] regs_reg [NR_REG];

    generate
        for (genvar gi = 0; gi < NR_REG; gi++) begin : g_reg
            localparam logic [RW-1:0] IDX = RW'(gi);
            // Entry 0 never matches the write condition, so it stays at its reset value.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regs_reg[gi] <= '0;
                end else if (we && (waddr == IDX) && (IDX != '0)) begin
                    regs_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata1 = (raddr1 == '0) ? 32'h0 : regs_reg[raddr1];
    assign rdata2 = (raddr2 == '0) ? 32'h0 : regs_reg[raddr2];

endmodule

// File: rtl/ysyx_23060221_wbu.sv
// Write-back unit: captures one retiring instruction from the LSU, commits it to
// the register file, then offers the next PC to the IFU. Optional instret
// counter enabled by defining YSYX_23060221_INSTRET_EN.
module ysyx_23060221_wbu
    import ysyx_23060221_pkg::*;
#(
    parameter int NR_REG = 16,
    localparam int RW = $clog2(NR_REG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LSU_valid,
    output logic          WBU_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_dnpc,
    input  logic [31:0]   in_res,
    input  logic [31:0]   in_ldata,
    input  logic [31:0]   in_csrdata,
    input  logic [RW-1:0] in_rd,
    input  logic          in_rfwen,
    input  logic [1:0]    in_wbsel,
    output logic          WBU_valid,
    input  logic          IFU_ready,
    output logic [31:0]   next_pc,
    input  logic [RW-1:0] raddr1,
    input  logic [RW-1:0] raddr2,
    output logic [31:0]   rdata1,
    output logic [31:0]   rdata2
`ifdef YSYX_23060221_INSTRET_EN
    ,
    output logic [63:0]   instret
`endif
);

    wbu_state_t    state_reg;
    logic          ready_reg;
    logic          valid_reg;
    logic [31:0]   next_pc_reg;
    logic [31:0]   wdata_reg;
    logic [RW-1:0] rd_reg;
    logic          rfwen_reg;
    logic [31:0]   wdata_next;

    // The PC only matters through pc+4, so it is folded into the captured value.
    assign wdata_next = wb_select(in_wbsel, in_res, in_ldata, in_pc, in_csrdata);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            ready_reg   <= 1'b1;
            valid_reg   <= 1'b0;
            next_pc_reg <= '0;
            wdata_reg   <= '0;
            rd_reg      <= '0;
            rfwen_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (LSU_valid && ready_reg) begin
                        next_pc_reg <= in_dnpc;
                        wdata_reg   <= wdata_next;
                        rd_reg      <= in_rd;
                        rfwen_reg   <= in_rfwen;
                        ready_reg   <= 1'b0;
                        state_reg   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    valid_reg <= 1'b1;
                    state_reg <= ST_NOTIFY;
                end
                ST_NOTIFY: begin
                    if (IFU_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign WBU_ready = ready_reg;
    assign WBU_valid = valid_reg;
    assign next_pc   = next_pc_reg;

    ysyx_23060221_regfile #(
        .NR_REG (NR_REG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     ((state_reg == ST_WRITE) && rfwen_reg),
        .waddr  (rd_reg),
        .wdata  (wdata_reg),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

`ifdef YSYX_23060221_INSTRET_EN
    logic [63:0] instret_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_reg <= '0;
        end else if ((state_reg == ST_NOTIFY) && IFU_ready) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign instret = instret_reg;
`endif

endmodule

// File: tb/tb_ysyx_23060221_wbu.sv
// Directed self-checking bench for ysyx_23060221_wbu (NR_REG = 16).
module tb_ysyx_23060221_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid;
    logic        wbu_ready;
    logic [31:0] in_pc, in_dnpc, in_res, in_ldata, in_csrdata;
    logic [3:0]  in_rd;
    logic        in_rfwen;
    logic [1:0]  in_wbsel;
    logic        wbu_valid;
    logic        ifu_ready;
    logic [31:0] next_pc;
    logic [3:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
`ifdef YSYX_23060221_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060221_wbu #(.NR_REG(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .LSU_valid  (lsu_valid),
        .WBU_ready  (wbu_ready),
        .in_pc      (in_pc),
        .in_dnpc    (in_dnpc),
        .in_res     (in_res),
        .in_ldata   (in_ldata),
        .in_csrdata (in_csrdata),
        .in_rd      (in_rd),
        .in_rfwen   (in_rfwen),
        .in_wbsel   (in_wbsel),
        .WBU_valid  (wbu_valid),
        .IFU_ready  (ifu_ready),
        .next_pc    (next_pc),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2)
`ifdef YSYX_23060221_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full retirement with IFU always ready: IDLE -> WRITE -> NOTIFY -> IDLE.
    task automatic retire(input logic [31:0] pc, input logic [31:0] dnpc,
                          input logic [31:0] res, input logic [31:0] ldata,
                          input logic [31:0] csr, input logic [3:0] rd,
                          input logic rfwen, input logic [1:0] sel);
        in_pc = pc; in_dnpc = dnpc; in_res = res; in_ldata = ldata;
        in_csrdata = csr; in_rd = rd; in_rfwen = rfwen; in_wbsel = sel;
        lsu_valid = 1'b1;
        ifu_ready = 1'b1;
        tick;
        lsu_valid  = 1'b0;
        in_pc      = 32'h5A5A_5A5A; in_res = 32'hA5A5_A5A5;
        in_ldata   = 32'h3C3C_3C3C; in_csrdata = 32'hC3C3_C3C3;
        in_rd      = 4'hF;
        tick;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; lsu_valid = 1'b0; ifu_ready = 1'b0;
        in_pc = '0; in_dnpc = '0; in_res = '0; in_ldata = '0; in_csrdata = '0;
        in_rd = '0; in_rfwen = 1'b0; in_wbsel = 2'b00;
        raddr1 = 4'd5; raddr2 = 4'd0;
        tick; tick;
        check_eq("rst_ready", wbu_ready, 1);
        check_eq("rst_valid", wbu_valid, 0);
        check_eq("rst_next_pc", next_pc, 0);
        check_eq("rst_x5", rdata1, 0);
`ifdef YSYX_23060221_INSTRET_EN
        check_eq("rst_instret", instret, 0);
`endif
        rst = 1'b1;

        // Basic ALU write-back with cycle-accurate timing
        in_pc = 32'h8000_0000; in_dnpc = 32'h8000_0004; in_res = 32'h1234_5678;
        in_rd = 4'd5; in_rfwen = 1'b1; in_wbsel = 2'b00; lsu_valid = 1'b1;
        tick;
        lsu_valid = 1'b0; in_res = 32'hFFFF_FFFF; in_dnpc = 32'h0;
        check_eq("t1_write_ready", wbu_ready, 0);
        check_eq("t1_write_valid", wbu_valid, 0);
        check_eq("t1_write_x5_old", rdata1, 0);
        ifu_ready = 1'b1;
        tick;
        check_eq("t1_notify_valid", wbu_valid, 1);
        check_eq("t1_notify_next_pc", next_pc, 32'h8000_0004);
        check_eq("t1_notify_x5", rdata1, 32'h1234_5678);
        tick;
        check_eq("t1_idle_ready", wbu_ready, 1);
        check_eq("t1_idle_valid", wbu_valid, 0);
        check_eq("t1_idle_x5", rdata1, 32'h1234_5678);

        // pc+4 wraps; x1 preloaded so a zero result is distinguishable
        raddr1 = 4'd1;
        retire(32'h0, 32'h4, 32'h0000_0055, 32'h0, 32'h0, 4'd1, 1'b1, 2'b00);
        check_eq("t2_x1_pre", rdata1, 32'h0000_0055);
        retire(32'hFFFF_FFFC, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 4'd1, 1'b1, 2'b10);
        check_eq("t2_x1_pc4_wrap", rdata1, 32'h0000_0000);

        // Load and CSR sources
        raddr1 = 4'd7; raddr2 = 4'd8;
        retire(32'h100, 32'h104, 32'h1, 32'hCAFE_0001, 32'h2, 4'd7, 1'b1, 2'b01);
        retire(32'h104, 32'h108, 32'h1, 32'h2, 32'h0BEE_F00D, 4'd8, 1'b1, 2'b11);
        check_eq("t2_x7_load", rdata1, 32'hCAFE_0001);
        check_eq("t2_x8_csr", rdata2, 32'h0BEE_F00D);

        // x0 write dropped, rfwen=0 drops write
        raddr1 = 4'd0; raddr2 = 4'd5;
        retire(32'h108, 32'h10C, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'd0, 1'b1, 2'b00);
        check_eq("t3_x0", rdata1, 0);
        check_eq("t3_x5_kept", rdata2, 32'h1234_5678);
        retire(32'h10C, 32'h110, 32'h0000_0999, 32'h0, 32'h0, 4'd5, 1'b0, 2'b00);
        check_eq("t3_rfwen0_x5", rdata2, 32'h1234_5678);

        // IFU back-pressure
        raddr1 = 4'd9; raddr2 = 4'd10;
        in_pc = 32'h200; in_dnpc = 32'h0000_0100; in_res = 32'h0BAD_F00D;
        in_rd = 4'd9; in_rfwen = 1'b1; in_wbsel = 2'b00;
        lsu_valid = 1'b1; ifu_ready = 1'b0;
        tick;
        in_dnpc = 32'h0000_0300; in_res = 32'h0000_0001; in_rd = 4'd10;
        tick;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t4_hold%0d_valid", i), wbu_valid, 1);
            check_eq($sformatf("t4_hold%0d_next_pc", i), next_pc, 32'h0000_0100);
            check_eq($sformatf("t4_hold%0d_ready", i), wbu_ready, 0);
            tick;
        end
        lsu_valid = 1'b0; ifu_ready = 1'b1;
        tick;
        check_eq("t4_release_ready", wbu_ready, 1);
        check_eq("t4_release_valid", wbu_valid, 0);
        check_eq("t4_x9", rdata1, 32'h0BAD_F00D);
        check_eq("t4_x10_untouched", rdata2, 0);

        // Reset during WRITE
        raddr1 = 4'd3; raddr2 = 4'd9;
        in_rd = 4'd3; in_ldata = 32'hAAAA_5555; in_wbsel = 2'b01; in_rfwen = 1'b1;
        in_dnpc = 32'h400; lsu_valid = 1'b1;
        tick;
        lsu_valid = 1'b0;
        check_eq("t5_in_write", wbu_ready, 0);
        #1 rst = 1'b0;
        #1;
        check_eq("t5_rst_ready", wbu_ready, 1);
        check_eq("t5_rst_valid", wbu_valid, 0);
        check_eq("t5_rst_next_pc", next_pc, 0);
        check_eq("t5_rst_x9_cleared", rdata2, 0);
        tick;
        rst = 1'b1;
        tick;
        check_eq("t5_x3_discarded", rdata1, 0);
        check_eq("t5_after_valid", wbu_valid, 0);

`ifdef YSYX_23060221_INSTRET_EN
        check_eq("t6_instret_rst", instret, 0);
        retire(32'h0, 32'h4, 32'h1, 32'h0, 32'h0, 4'd2, 1'b1, 2'b00);
        retire(32'h4, 32'h8, 32'h2, 32'h0, 32'h0, 4'd2, 1'b0, 2'b00);
        retire(32'h8, 32'hC, 32'h3, 32'h0, 32'h0, 4'd0, 1'b1, 2'b00);
        check_eq("t6_instret_3", instret, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060221_wbu.md
# ysyx_23060221_wbu

Write-back unit of the multi-cycle core, directly downstream of the load/store unit. Accepts one retiring instruction per LSU handshake, selects the write-back value, commits it to the integer register file it owns, then hands the next PC to the fetch unit through a valid/ready handshake. Also provides the two combinational register read ports used by decode.

## Interface
- `NR_REG`, 16: number of integer registers. Must be 16 or 32. `RW = $clog2(NR_REG)`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `LSU_valid`  in  1  LSU holds a retiring instruction.
- `WBU_ready`  out  1  WBU can accept from LSU.
- `in_pc`  in  32  PC of retiring instruction.
- `in_dnpc`  in  32  next PC computed upstream.
- `in_res`  in  32  ALU result.
- `in_ldata`  in  32  load data, already extended by the LSU.
- `in_csrdata`  in  32  CSR read value.
- `in_rd`  in  RW  destination register.
- `in_rfwen`  in  1  register write enable.
- `in_wbsel`  in  2  source select: 00 ALU, 01 load, 10 pc+4, 11 CSR.
- `WBU_valid`  out  1  next PC available to IFU.
- `IFU_ready`  in  1  IFU accepts next PC.
- `next_pc`  out  32  next PC.
- `raddr1`, `raddr2`  in  RW  read addresses.
- `rdata1`, `rdata2`  out  32  read data, combinational.

## Operation
- States: IDLE, WRITE, NOTIFY.
- IDLE: `WBU_ready`=1. On `LSU_valid & WBU_ready`, capture pc, dnpc, rd, rfwen and the selected write value into registers; go WRITE.
- Write value: wbsel 00 `in_res`; 01 `in_ldata`; 10 `in_pc + 4` (32-bit, wraps modulo 2^32); 11 `in_csrdata`. Selection happens at capture; inputs are don't-care afterwards.
- WRITE: if captured rfwen=1 and rd≠0, register rd takes the value at the end of this cycle. Go NOTIFY.
- NOTIFY: `WBU_valid`=1, `next_pc`=captured dnpc. On `IFU_ready`, go IDLE.
- Register 0 reads 0 always; writes to it are dropped.
- Reads see the pre-write value during WRITE (no bypass); new value visible from the NOTIFY cycle.

## Timing
- Reset (asserted anytime, including mid-WRITE/NOTIFY): state IDLE, `WBU_ready`=1, `WBU_valid`=0, `next_pc`=0, all registers 0, captured fields 0; a pending write is discarded.
- Handshake edge T → WRITE in T+1 → register updated at edge ending T+1 → `WBU_valid`=1 from T+2.
- Minimum LSU-handshake-to-IFU-handshake: 2 cycles; `WBU_ready` high again the cycle after the IFU handshake.
- `WBU_valid` and `next_pc` stay stable while `IFU_ready`=0; `WBU_ready`=0 outside IDLE, so no new instruction is taken while one is in flight.
- `WBU_ready` and `WBU_valid` are pure state decodes, no combinational path from `LSU_valid` or `IFU_ready`.

## Configuration
- `YSYX_23060221_INSTRET_EN`: defined adds output `instret` (64 bits, reset 0), incremented by 1 on each IFU handshake, wrapping at 2^64. Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `ysyx_23060221_pkg`: wbsel constants `WB_ALU`, `WB_LOAD`, `WB_PC4`, `WB_CSR`; state enum `wbu_state_t`.
- Sub-module `ysyx_23060221_regfile`: NR_REG×32 storage, one synchronous write port, two combinational read ports, x0 hardwired, async active-low clear.

## Test plan
- Reset release, LSU_valid=1, wbsel=00, rd=5, res=0x1234_5678, dnpc=0x8000_0004 → WBU_valid at T+2 with next_pc=0x8000_0004; raddr1=5 reads 0x1234_5678 from T+2.
- wbsel=10, pc=0xFFFF_FFFC, rd=1 → x1=0x0000_0000 (wrap).
- rd=0, rfwen=1, res=0xDEAD_BEEF → raddr1=0 reads 0; no other register changes.
- IFU_ready held low 5 cycles in NOTIFY → WBU_valid and next_pc stable, WBU_ready=0 despite LSU_valid=1; IFU_ready=1 → IDLE next cycle.
- Reset asserted in WRITE with rd=3, ldata=0xAAAA_5555 → x3=0, WBU_valid=0, WBU_ready=1 immediately.
- With INSTRET_EN: 3 back-to-back retirements → instret=3; rfwen=0 retirement still counts.
